// File: rtl/ysyx_22050243_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050243_mdu_ctrl
//  Description : Iterative RV64M multiply/divide sequencer. It accepts one
//                decoded M-op per valid/ready handshake and produces one
//                product or quotient bit per cycle. The result is held until
//                the consumer takes it.
//  Ports       : clk, rst (async, active-high), flush
//                in_valid/in_ready, mdu_op, is_w, src1, src2   - request side
//                out_valid/out_ready, result                   - response side
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050243_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mdu_op,
    input  logic            is_w,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN);

    localparam logic [CW-1:0]   c_last_w   = CW'(HALF - 1);
    localparam logic [CW-1:0]   c_last_x   = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_min_x    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_min_w    = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ones     = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_b;
    logic [2:0]          r_op;
    logic                r_is_w;
    logic                r_neg;      // product sign, or quotient sign for div/rem
    logic                r_s1neg;    // dividend sign, used for the remainder
    logic [XLEN-1:0]     r_result;

    // ---------------- request decode ----------------
    logic            w_is_w, w_is_div, w_s1_signed, w_s2_signed;
    logic [XLEN-1:0] w_op1, w_op2, w_mag1, w_mag2;
    logic            w_s1neg, w_s2neg, w_div0, w_ovf, w_special;
    logic [XLEN-1:0] w_spec_res;

    // mulh/mulhsu/mulhu have no W form; a stray is_w on them is ignored.
    assign w_is_w      = is_w && !(mdu_op == 3'd1 || mdu_op == 3'd2 || mdu_op == 3'd3);
    assign w_is_div    = mdu_op[2];
    assign w_s1_signed = !(mdu_op == 3'd3 || mdu_op == 3'd5 || mdu_op == 3'd7);
    assign w_s2_signed = (mdu_op == 3'd0 || mdu_op == 3'd1 || mdu_op == 3'd4 || mdu_op == 3'd6);

    assign w_op1 = !w_is_w      ? src1 :
                   w_s1_signed  ? sext_half(src1[HALF-1:0]) : {{HALF{1'b0}}, src1[HALF-1:0]};
    assign w_op2 = !w_is_w      ? src2 :
                   w_s2_signed  ? sext_half(src2[HALF-1:0]) : {{HALF{1'b0}}, src2[HALF-1:0]};

    assign w_s1neg = w_s1_signed && w_op1[XLEN-1];
    assign w_s2neg = w_s2_signed && w_op2[XLEN-1];
    assign w_mag1  = w_s1neg ? -w_op1 : w_op1;
    assign w_mag2  = w_s2neg ? -w_op2 : w_op2;

    assign w_div0    = w_is_div && (w_op2 == '0);
    assign w_ovf     = w_is_div && w_s1_signed && (w_op2 == c_ones) &&
                       (w_op1 == (w_is_w ? c_min_w : c_min_x));
    assign w_special = w_div0 || w_ovf;

    // Divide-by-zero wins over overflow (the divisor cannot be both 0 and -1).
    always_comb begin
        w_spec_res = '0;
        if (w_div0) begin
            if (!mdu_op[1]) w_spec_res = c_ones;
            else            w_spec_res = w_is_w ? sext_half(src1[HALF-1:0]) : src1;
        end else if (!mdu_op[1]) begin
            w_spec_res = w_op1;          // min_int at the working width
        end
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     w_madd;
    logic [XLEN:0]     w_rsh;
    logic              w_ge;
    logic [XLEN-1:0]   w_rsub;
    logic [2*XLEN-1:0] w_acc_next;

    // Multiply: add the multiplicand into the high half when the current
    // multiplier bit (LSB) is set, then shift the whole accumulator right.
    assign w_madd = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    // Divide: high half is the partial remainder, low half shifts the dividend
    // out at the top and collects quotient bits at the bottom.
    assign w_rsh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_ge   = (w_rsh >= {1'b0, r_b});
    assign w_rsub = w_rsh[XLEN-1:0] - r_b;   // result < divisor, so XLEN bits suffice

    assign w_acc_next = r_op[2] ?
        {(w_ge ? w_rsub : w_rsh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge} :
        {w_madd, r_acc[XLEN-1:1]};

    // ---------------- final result formatting ----------------
    logic [2*XLEN-1:0] w_prod_al, w_prod;
    logic [XLEN-1:0]   w_mul_res, w_dval, w_dres, w_div_res, w_final;
    logic              w_dneg;
    logic              w_last;

    // After HALF steps a W multiply leaves its product shifted up by HALF.
    assign w_prod_al = r_is_w ? (w_acc_next >> HALF) : w_acc_next;
    assign w_prod    = r_neg ? -w_prod_al : w_prod_al;
    assign w_mul_res = (r_op == 3'd0) ?
                       (r_is_w ? sext_half(w_prod[HALF-1:0]) : w_prod[XLEN-1:0]) :
                       w_prod[2*XLEN-1:XLEN];

    assign w_dval    = r_op[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
    assign w_dneg    = r_op[1] ? r_s1neg : r_neg;
    assign w_dres    = w_dneg ? -w_dval : w_dval;
    assign w_div_res = r_is_w ? sext_half(w_dres[HALF-1:0]) : w_dres;

    assign w_final = r_op[2] ? w_div_res : w_mul_res;
    assign w_last  = (r_cnt == (r_is_w ? c_last_w : c_last_x));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_next = w_special ? S_DONE : S_CALC;
                S_CALC:  if (w_last)   w_next = S_DONE;
                S_DONE:  if (out_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_is_w   <= 1'b0;
            r_neg    <= 1'b0;
            r_s1neg  <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt   <= '0;
                        r_op    <= mdu_op;
                        r_is_w  <= w_is_w;
                        r_neg   <= w_s1neg ^ w_s2neg;
                        r_s1neg <= w_s1neg;
                        r_b     <= w_mag2;
                        // W divide left-aligns the 32-bit dividend so its MSB goes first.
                        if (w_is_div && w_is_w)
                            r_acc <= {{XLEN{1'b0}}, w_mag1[HALF-1:0], {HALF{1'b0}}};
                        else
                            r_acc <= {{XLEN{1'b0}}, w_mag1};
                        if (w_special) r_result <= w_spec_res;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_result <= w_final;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050243_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22050243_mdu_ctrl
//  Description : Self-checking bench for the RV64M multiply/divide sequencer.
//                Expected results come from a plain-arithmetic reference
//                model of the RV64M instruction semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050243_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  mdu_op = 3'd0;
    logic        is_w = 1'b0;
    logic [63:0] src1 = 64'd0;
    logic [63:0] src2 = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;
    logic [63:0] last_res = 64'd0;

    ysyx_22050243_mdu_ctrl #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mdu_op    (mdu_op),
        .is_w      (is_w),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic eff_w(input logic [2:0] op, input logic w);
        return w && !(op == 3'd1 || op == 3'd2 || op == 3'd3);
    endfunction

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic w_in,
                                               input logic [63:0] a, input logic [63:0] b);
        logic w;
        logic signed [127:0] pa, pb, p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] xa, xb;
        logic [31:0] ua, ub, t32;
        w  = eff_w(op, w_in);
        sa = a; sb = b; xa = a[31:0]; xb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        case (op)
            3'd0: begin
                if (w) begin t32 = ua * ub; return sx32(t32); end
                return a * b;
            end
            3'd1: begin pa = sa; pb = sb; p = pa * pb; return p[127:64]; end
            3'd2: begin pa = sa; pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            3'd4, 3'd6: begin
                if (w) begin
                    if (xb == 0)                           t32 = (op == 3'd4) ? 32'hFFFF_FFFF : ua;
                    else if (xa == -32'sd2147483648 && xb == -32'sd1) t32 = (op == 3'd4) ? ua : 32'd0;
                    else                                   t32 = (op == 3'd4) ? xa / xb : xa % xb;
                    return sx32(t32);
                end
                if (sb == 0)                                    return (op == 3'd4) ? 64'hFFFF_FFFF_FFFF_FFFF : a;
                if (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) return (op == 3'd4) ? a : 64'd0;
                return (op == 3'd4) ? sa / sb : sa % sb;
            end
            default: begin
                if (w) begin
                    if (ub == 0) t32 = (op == 3'd5) ? 32'hFFFF_FFFF : ua;
                    else         t32 = (op == 3'd5) ? ua / ub : ua % ub;
                    return sx32(t32);
                end
                if (b == 0) return (op == 3'd5) ? 64'hFFFF_FFFF_FFFF_FFFF : a;
                return (op == 3'd5) ? a / b : a % b;
            end
        endcase
    endfunction

    // Cycle (counting the accept cycle as 0) in which out_valid first shows.
    function automatic int ref_latency(input logic [2:0] op, input logic w_in,
                                       input logic [63:0] a, input logic [63:0] b);
        logic w;
        logic sgn;
        w   = eff_w(op, w_in);
        sgn = (op == 3'd4 || op == 3'd6);
        if (op[2]) begin
            if (w && b[31:0] == 32'd0) return 1;
            if (!w && b == 64'd0) return 1;
            if (sgn && w && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            if (sgn && !w && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
        end
        return w ? 33 : 65;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Issue one op from IDLE and wait for out_valid; cyc is the observed cycle.
    task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output int cyc);
        in_valid = 1'b1; mdu_op = op; is_w = w; src1 = a; src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 64'(longint'($urandom_range(0, 20)));
            1: return -64'(longint'($urandom_range(1, 20)));
            2: return 64'd0;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_FFFF_FFFF;
            5: return {32'($urandom), 32'h8000_0000};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    endtask

    task automatic test_mul_hold();
        int cyc;
        logic [63:0] exp;
        exp = ref_result(3'd0, 1'b0, 64'd7, -64'd3);
        do_op(3'd0, 1'b0, 64'd7, -64'd3, cyc);
        checks++; if (cyc != 65) begin failures++; $display("FAIL mul_latency got=%0d exp=65", cyc); end
        checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB || exp !== 64'hFFFF_FFFF_FFFF_FFEB)
            begin failures++; $display("FAIL mul_result got=%h exp=%h", result, 64'hFFFF_FFFF_FFFF_FFEB); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp)
                begin failures++; $display("FAIL mul_hold cyc%0d got v=%b r=%b res=%h exp v=1 r=0 res=%h", i, out_valid, in_ready, result, exp); end
        end
        consume();
        last_res = exp;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL mul_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [10] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd6, 3'd4, 3'd6};
        logic        ws  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] as  [10] = '{64'hFFFF_FFFF_FFFF_FFFF, -64'd1, -64'd1, -64'd7, -64'd7,
                                  64'hFFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 64'd5,
                                  64'h8000_0000_0000_0000, 64'h8000_0000};
        logic [63:0] bs  [10] = '{64'd2, -64'd1, 64'd2, 64'd2, 64'd2, 64'd1, 64'd0, 64'd0,
                                  -64'd1, -64'd1};
        logic [63:0] ex  [10] = '{64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
                                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                  64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
        int          lat [10] = '{65, 65, 65, 65, 65, 33, 1, 1, 1, 1};
        int cyc;
        for (int i = 0; i < 10; i++) begin
            do_op(ops[i], ws[i], as[i], bs[i], cyc);
            checks++; if (result !== ex[i])
                begin failures++; $display("FAIL directed%0d_result got=%h exp=%h", i, result, ex[i]); end
            checks++; if (cyc != lat[i])
                begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, cyc, lat[i]); end
            consume();
            last_res = ex[i];
        end
    endtask

    task automatic test_flush();
        int cyc;
        bit rose;
        in_valid = 1'b1; mdu_op = 3'd4; is_w = 1'b0; src1 = 64'd1000; src2 = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 20) begin @(posedge clk); #1; cyc++; end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_pre got=%b exp=0", out_valid); end
        flush = 1'b1; in_valid = 1'b1; mdu_op = 3'd5; src1 = 64'd9; src2 = 64'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL flush_idle got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
        checks++; if (result !== last_res)
            begin failures++; $display("FAIL flush_result_hold got=%h exp=%h", result, last_res); end
        rose = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) rose = 1'b1;
        end
        checks++; if (rose) begin failures++; $display("FAIL flush_no_valid got=1 exp=0"); end
        do_op(3'd5, 1'b0, 64'd100, 64'd7, cyc);
        checks++; if (result !== 64'd14 || cyc != 65)
            begin failures++; $display("FAIL flush_next_divu got=%h@%0d exp=%h@65", result, cyc, 64'd14); end
        consume();
        last_res = 64'd14;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] a1, b1, a2, b2, e1, e2;
        a1 = pick_val(); b1 = pick_val(); a2 = pick_val(); b2 = pick_val();
        e1 = ref_result(3'd1, 1'b0, a1, b1);
        e2 = ref_result(3'd7, 1'b0, a2, b2);
        do_op(3'd1, 1'b0, a1, b1, cyc);
        checks++; if (result !== e1) begin failures++; $display("FAIL b2b_first got=%h exp=%h", result, e1); end
        out_ready = 1'b1;
        in_valid = 1'b1; mdu_op = 3'd7; is_w = 1'b0; src1 = a2; src2 = b2;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_done_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin failures++; $display("FAIL b2b_idle got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b exp=0", in_ready); end
        cyc = 1;
        while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
        checks++; if (result !== e2 || cyc != ref_latency(3'd7, 1'b0, a2, b2))
            begin failures++; $display("FAIL b2b_second got=%h@%0d exp=%h@%0d", result, cyc, e2, ref_latency(3'd7, 1'b0, a2, b2)); end
        consume();
        last_res = e2;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; mdu_op = 3'd0; is_w = 1'b0; src1 = 64'd123; src2 = 64'd456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'd0)
            begin failures++; $display("FAIL async_rst got v=%b r=%b res=%h exp v=0 r=1 res=0", out_valid, in_ready, result); end
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = 64'd0;
    endtask

    task automatic test_random();
        int cyc, lat, d;
        logic [2:0] op;
        logic w;
        logic [63:0] a, b, e;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = pick_val();
            b  = pick_val();
            e   = ref_result(op, w, a, b);
            lat = ref_latency(op, w, a, b);
            do_op(op, w, a, b, cyc);
            checks++; if (result !== e || cyc != lat)
                begin failures++; $display("FAIL rand%0d op=%0d w=%b a=%h b=%h got=%h@%0d exp=%h@%0d", n, op, w, a, b, result, cyc, e, lat); end
            d = $urandom_range(0, 3);
            repeat (d) begin @(posedge clk); #1; end
            checks++; if (out_valid !== 1'b1 || result !== e)
                begin failures++; $display("FAIL rand%0d_hold got v=%b res=%h exp v=1 res=%h", n, out_valid, result, e); end
            consume();
            last_res = e;
        end
    endtask

    initial begin
        #17 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_mul_hold();
        test_directed();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
